keypad_digit_buffer: RTL and testbench

Sequential stage directly downstream of decimal_bcd_encoder in the DigiLock datapath. It consumes the encoder's 4-bit BCD code plus a key-present flag, debounces each press, and rejects auto-repeat. Accepted digits are shifted into an N-digit entry register. When the entry is complete it raises code_ready for the comparator/FSM stage, and an idle timeout discards partial entries.

---
 rtl/digilock_pkg.sv | 19 +
 rtl/press_debouncer.sv | 58 +++++
 rtl/keypad_digit_buffer.sv | 149 ++++++++++++++
 tb/tb_keypad_digit_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/digilock_pkg.sv
// Shared definitions for the DigiLock keypad path.
// Holds the FSM state encoding, the largest legal BCD digit and the default
// code length used by keypad_digit_buffer.
package digilock_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_FULL     = 2'd3;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         DEF_NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_DEBOUNCE = ST_DEBOUNCE,
    S_HELD     = ST_HELD,
    S_FULL     = ST_FULL
  } state_e;
endpackage

// File: rtl/press_debouncer.sv
// Press debouncer: latches the code seen when a press starts and counts
// consecutive samples that still match it.
//   clock, reset : system clock / async active-high reset
//   load         : first sample of a new press (latch bcd, count = 1)
//   active       : owner FSM is in its debounce state
//   flush        : synchronous discard (clear)
//   key_valid,bcd: raw keypad inputs
//   sample       : code latched at press start
//   stable       : key still down with the same code
//   accept       : stable for DEBOUNCE_CYCLES counted samples
module press_debouncer #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       active,
  input  logic       flush,
  input  logic       key_valid,
  input  logic [3:0] bcd,
  output logic [3:0] sample,
  output logic       stable,
  output logic       accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    sample_q, sample_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;

  assign sample = sample_q;
  assign stable = key_valid && (bcd == sample_q);
  // Acceptance is judged on the stored count, so DEBOUNCE_CYCLES=1 accepts
  // on the first edge after the press was latched.
  assign accept = active && stable && (deb_cnt_q == CW'(DEBOUNCE_CYCLES));

  always_comb begin
    sample_d  = sample_q;
    deb_cnt_d = '0;
    if (flush) begin
      sample_d = '0;
    end else if (load) begin
      sample_d  = bcd;
      deb_cnt_d = CW'(1);
    end else if (active && stable && !accept) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q  <= '0;
      deb_cnt_q <= '0;
    end else begin
      sample_q  <= sample_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end
endmodule

// File: rtl/keypad_digit_buffer.sv
// Keypad digit buffer: debounces BCD key presses, blocks auto-repeat, shifts
// accepted digits into an N-digit entry (first digit in the top nibble),
// flags completion and discards stale partial entries after an idle timeout.
//   clock, reset  : system clock / async active-high reset
//   bcd, key_valid: encoder code and key-down flag
//   clear         : synchronous discard, highest priority
//   consume       : downstream took the completed code (FULL only)
//   digits, count : entry register and number of digits held
//   digit_strobe, bcd_error, timeout : registered one-cycle pulses
//   code_ready    : entry complete (decoded from state)
module keypad_digit_buffer
  import digilock_pkg::*;
#(
  parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              bcd,
  input  logic                    key_valid,
  input  logic                    clear,
  input  logic                    consume,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [2:0]              count,
  output logic                    digit_strobe,
  output logic                    code_ready,
  output logic                    bcd_error,
  output logic                    timeout
);
  localparam int IW = $clog2(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [2:0]              count_q, count_d;
  logic [IW-1:0]           idle_cnt_q, idle_cnt_d;
  logic                    strobe_q, strobe_d;
  logic                    err_q, err_d;
  logic                    to_q, to_d;

  logic [3:0] sample;
  logic       stable, accept, partial;

  press_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock     (clock),
    .reset     (reset),
    .load      (state_q == S_IDLE && key_valid && !clear),
    .active    (state_q == S_DEBOUNCE),
    .flush     (clear),
    .key_valid (key_valid),
    .bcd       (bcd),
    .sample    (sample),
    .stable    (stable),
    .accept    (accept)
  );

  assign partial = (count_q != 3'd0) && (count_q < 3'(NUM_DIGITS));

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    count_d    = count_q;
    idle_cnt_d = '0;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A press on the timeout edge wins; the idle counter restarts.
        if (key_valid) begin
          state_d = S_DEBOUNCE;
        end else if (partial) begin
          if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
            digits_d = '0;
            count_d  = '0;
            to_d     = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!stable) begin
          state_d = S_IDLE;
        end else if (accept) begin
          state_d = S_HELD;
          if (sample <= BCD_MAX) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--)
              digits_d[4*i +: 4] = digits_q[4*(i-1) +: 4];
            digits_d[3:0] = sample;
            count_d  = (count_q == 3'(NUM_DIGITS)) ? count_q : count_q + 3'd1;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HELD: begin
        // Stay here until release so a held key cannot auto-repeat.
        if (!key_valid)
          state_d = (count_q == 3'(NUM_DIGITS)) ? S_FULL : S_IDLE;
      end
      S_FULL: begin
        if (consume) begin
          digits_d = '0;
          count_d  = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d    = S_IDLE;
      digits_d   = '0;
      count_d    = '0;
      idle_cnt_d = '0;
      strobe_d   = 1'b0;
      err_d      = 1'b0;
      to_d       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      count_q    <= '0;
      idle_cnt_q <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      idle_cnt_q <= idle_cnt_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign digits       = digits_q;
  assign count        = count_q;
  assign digit_strobe = strobe_q;
  assign bcd_error    = err_q;
  assign timeout      = to_q;
  assign code_ready   = (state_q == S_FULL);
endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Directed bench for keypad_digit_buffer (defaults: 4 digits, 3-cycle
// debounce, 1000-cycle timeout). Expected pulses are queued when stimulus is
// driven and popped by a negedge monitor when the DUT emits a pulse.
module tb_keypad_digit_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  bcd;
  logic        key_valid, clear, consume;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        digit_strobe, code_ready, bcd_error, timeout;

  localparam int K_STROBE = 0, K_ERR = 1, K_TO = 2;
  typedef struct { int kind; int cnt; } sb_item_t;
  sb_item_t sb[$];

  int checks = 0;
  int passed = 0;

  keypad_digit_buffer dut (
    .clock(clock), .reset(reset), .bcd(bcd), .key_valid(key_valid),
    .clear(clear), .consume(consume), .digits(digits), .count(count),
    .digit_strobe(digit_strobe), .code_ready(code_ready),
    .bcd_error(bcd_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_pulse(input int kind, input int cnt);
    sb_item_t it;
    it.kind = kind;
    it.cnt  = cnt;
    sb.push_back(it);
  endtask

  // Hold a key for 'hold' edges, then release for one edge.
  task automatic press(input logic [3:0] code, input int hold);
    bcd       = code;
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    tick();
  endtask

  // Pulse scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && (digit_strobe || bcd_error || timeout)) begin
      int kind;
      sb_item_t it;
      chk("pulse_exclusive", 32'(digit_strobe) + 32'(bcd_error) + 32'(timeout), 32'd1);
      kind = digit_strobe ? K_STROBE : (bcd_error ? K_ERR : K_TO);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", 32'(kind), 32'hFF);
      end else begin
        it = sb.pop_front();
        chk("pulse_kind", 32'(kind), 32'(it.kind));
        chk("pulse_count", 32'(count), 32'(it.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1; bcd = '0; key_valid = 1'b0; clear = 1'b0; consume = 1'b0;
    #2;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_pulses", {29'd0, digit_strobe, bcd_error, timeout}, 32'd0);
    chk("reset_ready", 32'(code_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: press 7 for 5 cycles -> one strobe after debounce
    expect_pulse(K_STROBE, 1);
    bcd = 4'd7; key_valid = 1'b1;
    repeat (3) tick();
    chk("t1_no_early_strobe", 32'(digit_strobe), 32'd0);
    tick();
    chk("t1_strobe", 32'(digit_strobe), 32'd1);
    chk("t1_digit", 32'(digits[3:0]), 32'd7);
    chk("t1_count", 32'(count), 32'd1);
    tick();
    chk("t1_strobe_one_cycle", 32'(digit_strobe), 32'd0);
    key_valid = 1'b0;
    tick();
    chk("t1_count_after_release", 32'(count), 32'd1);

    // 2: 2-cycle glitch -> nothing taken
    key_valid = 1'b1; bcd = 4'd2;
    repeat (2) tick();
    key_valid = 1'b0;
    repeat (3) tick();
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_digits", 32'(digits), 32'h0007);

    // 3: fill 1,9,0,4 -> FULL; extra press ignored; consume empties
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3_cleared", 32'(count), 32'd0);
    expect_pulse(K_STROBE, 1); press(4'd1, 4);
    expect_pulse(K_STROBE, 2); press(4'd9, 4);
    expect_pulse(K_STROBE, 3); press(4'd0, 4);
    expect_pulse(K_STROBE, 4); press(4'd4, 4);
    chk("t3_digits", 32'(digits), 32'h1904);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_ready", 32'(code_ready), 32'd1);
    press(4'd5, 6);
    chk("t3_ignored_digits", 32'(digits), 32'h1904);
    chk("t3_still_ready", 32'(code_ready), 32'd1);
    consume = 1'b1; tick(); consume = 1'b0;
    chk("t3_consume_ready", 32'(code_ready), 32'd0);
    chk("t3_consume_digits", 32'(digits), 32'h0);
    chk("t3_consume_count", 32'(count), 32'd0);
    consume = 1'b1; tick(); consume = 1'b0;
    chk("t3_consume_outside_full", 32'(count), 32'd0);

    // 4: timeout on the 1000th idle edge
    expect_pulse(K_STROBE, 1); press(4'd3, 4);
    repeat (999) tick();
    chk("t4_no_early_timeout", 32'(timeout), 32'd0);
    chk("t4_count_before", 32'(count), 32'd1);
    expect_pulse(K_TO, 0);
    tick();
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_digits", 32'(digits), 32'h0);
    chk("t4_count", 32'(count), 32'd0);
    tick();
    chk("t4_timeout_one_cycle", 32'(timeout), 32'd0);
    // press landing on the timeout edge wins
    expect_pulse(K_STROBE, 1); press(4'd3, 4);
    repeat (999) tick();
    bcd = 4'd6; key_valid = 1'b1;
    expect_pulse(K_STROBE, 2);
    tick();
    chk("t4b_no_timeout", 32'(timeout), 32'd0);
    chk("t4b_count_kept", 32'(count), 32'd1);
    repeat (3) tick();
    chk("t4b_digits", 32'(digits[7:0]), 32'h36);
    chk("t4b_count", 32'(count), 32'd2);
    key_valid = 1'b0; tick();

    // 5: code 12 -> bcd_error, no shift
    clear = 1'b1; tick(); clear = 1'b0;
    expect_pulse(K_STROBE, 1); press(4'd2, 4);
    expect_pulse(K_ERR, 1);
    bcd = 4'd12; key_valid = 1'b1;
    repeat (4) tick();
    chk("t5_error", 32'(bcd_error), 32'd1);
    chk("t5_no_strobe", 32'(digit_strobe), 32'd0);
    repeat (2) tick();
    key_valid = 1'b0; tick();
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_digits", 32'(digits), 32'h0002);

    // 6a: async reset mid-debounce
    bcd = 4'd8; key_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    #2;
    chk("t6_reset_count", 32'(count), 32'd0);
    chk("t6_reset_digits", 32'(digits), 32'h0);
    key_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    // 6b: clear on the accept edge, then a still-held key re-debounces
    expect_pulse(K_STROBE, 1); press(4'd4, 4);
    bcd = 4'd5; key_valid = 1'b1;
    repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t6_clear_strobe", 32'(digit_strobe), 32'd0);
    chk("t6_clear_count", 32'(count), 32'd0);
    chk("t6_clear_digits", 32'(digits), 32'h0);
    expect_pulse(K_STROBE, 1);
    repeat (4) tick();
    chk("t6_redebounce_strobe", 32'(digit_strobe), 32'd1);
    chk("t6_redebounce_digit", 32'(digits), 32'h0005);
    key_valid = 1'b0;
    repeat (3) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
